// File: rtl/irq_ctrl.sv
// Interrupt controller in front of the picorv32 irq input: synchronises peripheral
// requests, latches edge/level events into PENDING, masks them with ENABLE and drives irq_o.
module irq_ctrl #(
   parameter int NUM_SRC     = 8,
   parameter int IRQ_BASE    = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               irq_sel,
   input  logic [3:0]         addr,
   input  logic [3:0]         wstrb,
   input  logic [31:0]        data_i,
   output logic               irq_ready,
   output logic [31:0]        data_o,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic [31:0]        eoi,
   output logic [31:0]        irq_o
);

   localparam logic [1:0] REG_PENDING = 2'd0;
   localparam logic [1:0] REG_ENABLE  = 2'd1;
   localparam logic [1:0] REG_EDGE    = 2'd2;
   localparam logic [1:0] REG_STATUS  = 2'd3;

   logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
   logic [NUM_SRC-1:0] hist_q;
   logic [NUM_SRC-1:0] pending_q;
   logic [NUM_SRC-1:0] enable_q;
   logic [NUM_SRC-1:0] edge_q;

   logic [NUM_SRC-1:0] sync;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] status;
   logic [NUM_SRC-1:0] w1c;
   logic [NUM_SRC-1:0] eoi_src;
   logic [NUM_SRC-1:0] pending_d;
   logic [NUM_SRC-1:0] wr_bits;
   logic [NUM_SRC-1:0] wr_mask;
   logic [31:0]        byte_mask;
   logic [31:0]        rdata;
   logic [31:0]        status_ext;
   logic               accept;
   logic               wr_en;
   logic               unused_bits;

   assign accept  = irq_sel & ~irq_ready;
   assign wr_en   = accept & (wstrb != 4'b0000);
   assign sync    = sync_q[SYNC_STAGES-1];
   assign rise    = sync & ~hist_q;
   assign status  = pending_q & enable_q;
   assign eoi_src = eoi[IRQ_BASE +: NUM_SRC];
   assign wr_mask = byte_mask[NUM_SRC-1:0];
   assign wr_bits = data_i[NUM_SRC-1:0];
   assign w1c     = (wr_en && addr[3:2] == REG_PENDING) ? (wr_bits & wr_mask) : '0;

   // Edge bits: a new rise beats any clear landing on the same cycle.
   // Level bits: follow the synchronised input, clears have no effect.
   assign pending_d = (edge_q & (rise | (pending_q & ~(w1c | eoi_src)))) | (~edge_q & sync);

   assign unused_bits = ^{addr[1:0], eoi, data_i, byte_mask};

   always_comb begin
      byte_mask = '0;
      for (int k = 0; k < 4; k++) begin
         byte_mask[8*k +: 8] = {8{wstrb[k]}};
      end
   end

   always_comb begin
      rdata = '0;
      case (addr[3:2])
         REG_PENDING: rdata[NUM_SRC-1:0] = pending_q;
         REG_ENABLE:  rdata[NUM_SRC-1:0] = enable_q;
         REG_EDGE:    rdata[NUM_SRC-1:0] = edge_q;
         REG_STATUS:  rdata[NUM_SRC-1:0] = status;
         default:     rdata = '0;
      endcase
   end

   always_comb begin
      status_ext = '0;
      status_ext[NUM_SRC-1:0] = status;
   end

   // History keeps tracking in both modes so an EDGE change never fakes a rise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= '0;
         end
         hist_q    <= '0;
         pending_q <= '0;
      end else begin
         sync_q[0] <= irq_src;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
         hist_q    <= sync;
         pending_q <= pending_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_ready <= 1'b0;
         data_o    <= '0;
         enable_q  <= '0;
         edge_q    <= '0;
      end else begin
         irq_ready <= accept;
         data_o    <= accept ? rdata : '0;
         if (wr_en && addr[3:2] == REG_ENABLE) begin
            enable_q <= (enable_q & ~wr_mask) | (wr_bits & wr_mask);
         end
         if (wr_en && addr[3:2] == REG_EDGE) begin
            edge_q <= (edge_q & ~wr_mask) | (wr_bits & wr_mask);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_o <= '0;
      end else begin
         irq_o <= status_ext << IRQ_BASE;
      end
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: bus handshake, register access, edge/level latching and gating.
module tb_irq_ctrl;

   logic        clk;
   logic        reset;
   logic        irq_sel;
   logic [3:0]  addr;
   logic [3:0]  wstrb;
   logic [31:0] data_i;
   logic        irq_ready;
   logic [31:0] data_o;
   logic [7:0]  irq_src;
   logic [31:0] eoi;
   logic [31:0] irq_o;

   int n_vec;
   int n_err;

   irq_ctrl #(.NUM_SRC(8), .IRQ_BASE(3), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .irq_sel   (irq_sel),
      .addr      (addr),
      .wstrb     (wstrb),
      .data_i    (data_i),
      .irq_ready (irq_ready),
      .data_o    (data_o),
      .irq_src   (irq_src),
      .eoi       (eoi),
      .irq_o     (irq_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One access: select at a falling edge, sample ready/data after the accepting edge.
   task automatic bus(input logic [3:0] a, input logic [3:0] ws, input logic [31:0] d,
                      output logic [31:0] rd, output logic rdy);
      @(negedge clk);
      irq_sel = 1'b1; addr = a; wstrb = ws; data_i = d;
      @(posedge clk); #1;
      rdy = irq_ready;
      rd  = data_o;
      @(negedge clk);
      irq_sel = 1'b0; wstrb = 4'b0000; data_i = '0;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      logic        rdy;
      n_vec++; if (irq_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", irq_ready); end
      n_vec++; if (data_o !== 32'h0) begin n_err++; $display("FAIL reset_data got %h want 0", data_o); end
      n_vec++; if (irq_o !== 32'h0) begin n_err++; $display("FAIL reset_irq got %h want 0", irq_o); end
      @(negedge clk);
      irq_sel = 1'b1; addr = 4'h0; wstrb = 4'b0000;
      #1;
      n_vec++; if (irq_ready !== 1'b0) begin n_err++; $display("FAIL ready_before_edge got %b want 0", irq_ready); end
      @(posedge clk); #1;
      n_vec++; if (irq_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_edge got %b want 1", irq_ready); end
      @(negedge clk); irq_sel = 1'b0;
      @(posedge clk); #1;
      n_vec++; if (irq_ready !== 1'b0) begin n_err++; $display("FAIL ready_falls got %b want 0", irq_ready); end
      for (int r = 0; r < 4; r++) begin
         bus(4'(r * 4), 4'b0000, 32'h0, rd, rdy);
         n_vec++; if (rdy !== 1'b1) begin n_err++; $display("FAIL reset_read_rdy[%0d] got %b want 1", r, rdy); end
         n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL reset_read_data[%0d] got %h want 0", r, rd); end
      end
      n_vec++; if (irq_o !== 32'h0) begin n_err++; $display("FAIL reset_irq_after_reads got %h want 0", irq_o); end
   endtask

   task automatic test_enable_write();
      logic [31:0] rd;
      logic        rdy;
      int          pulses;
      bus(4'h4, 4'b0001, 32'h0000_00FF, rd, rdy);
      bus(4'h4, 4'b0010, 32'hFFFF_FFFF, rd, rdy);
      bus(4'h4, 4'b0000, 32'h0, rd, rdy);
      n_vec++; if (rd !== 32'h0000_00FF) begin n_err++; $display("FAIL enable_readback got %h want 000000ff", rd); end
      // select held over two sampling edges
      pulses = 0;
      @(negedge clk);
      irq_sel = 1'b1; addr = 4'h4; wstrb = 4'b0000;
      @(posedge clk); #1;
      if (irq_ready === 1'b1) pulses++;
      n_vec++; if (data_o !== 32'h0000_00FF) begin n_err++; $display("FAIL held_sel_data got %h want 000000ff", data_o); end
      @(posedge clk); #1;
      if (irq_ready === 1'b1) pulses++;
      n_vec++; if (data_o !== 32'h0) begin n_err++; $display("FAIL data_idle got %h want 0", data_o); end
      @(negedge clk); irq_sel = 1'b0;
      @(posedge clk); #1;
      if (irq_ready === 1'b1) pulses++;
      n_vec++; if (pulses !== 1) begin n_err++; $display("FAIL held_sel_pulses got %0d want 1", pulses); end
      // select withdrawn between sampling edges gives no pulse
      irq_sel = 1'b1; #2; irq_sel = 1'b0;
      @(posedge clk); #1;
      n_vec++; if (irq_ready !== 1'b0) begin n_err++; $display("FAIL short_sel_ready got %b want 0", irq_ready); end
   endtask

   task automatic test_edge();
      logic [31:0] rd;
      logic        rdy;
      bus(4'h8, 4'b1111, 32'h0000_0001, rd, rdy);
      bus(4'h4, 4'b1111, 32'h0000_0001, rd, rdy);
      @(negedge clk); irq_src[0] = 1'b1;
      @(posedge clk); #1;
      n_vec++; if (irq_o !== 32'h0) begin n_err++; $display("FAIL edge_irq_N got %h want 0", irq_o); end
      @(negedge clk); irq_src[0] = 1'b0;
      @(posedge clk); #1;
      n_vec++; if (irq_o !== 32'h0) begin n_err++; $display("FAIL edge_irq_N1 got %h want 0", irq_o); end
      @(posedge clk); #1;
      n_vec++; if (irq_o !== 32'h0) begin n_err++; $display("FAIL edge_irq_N2 got %h want 0", irq_o); end
      @(posedge clk); #1;
      n_vec++; if (irq_o !== 32'h0000_0008) begin n_err++; $display("FAIL edge_irq_N3 got %h want 00000008", irq_o); end
      bus(4'hC, 4'b0000, 32'h0, rd, rdy);
      n_vec++; if (rd !== 32'h0000_0001) begin n_err++; $display("FAIL edge_status got %h want 00000001", rd); end
      bus(4'h0, 4'b1111, 32'h0000_0001, rd, rdy);
      n_vec++; if (irq_o !== 32'h0000_0008) begin n_err++; $display("FAIL w1c_irq_at_ready got %h want 00000008", irq_o); end
      @(posedge clk); #1;
      n_vec++; if (irq_o !== 32'h0) begin n_err++; $display("FAIL w1c_irq_after got %h want 0", irq_o); end
   endtask

   task automatic test_level();
      logic [31:0] rd;
      logic        rdy;
      bus(4'h4, 4'b1111, 32'h0000_0002, rd, rdy);
      @(negedge clk); irq_src[1] = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_vec++; if (irq_o !== 32'h0) begin n_err++; $display("FAIL level_irq_N1 got %h want 0", irq_o); end
      @(posedge clk); @(posedge clk); #1;
      n_vec++; if (irq_o !== 32'h0000_0010) begin n_err++; $display("FAIL level_irq_N3 got %h want 00000010", irq_o); end
      bus(4'h0, 4'b1111, 32'h0000_0002, rd, rdy);
      @(posedge clk); #1;
      n_vec++; if (irq_o !== 32'h0000_0010) begin n_err++; $display("FAIL level_w1c_irq got %h want 00000010", irq_o); end
      bus(4'h0, 4'b0000, 32'h0, rd, rdy);
      n_vec++; if (rd !== 32'h0000_0002) begin n_err++; $display("FAIL level_pending got %h want 00000002", rd); end
      @(negedge clk); irq_src[1] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++; if (irq_o !== 32'h0000_0010) begin n_err++; $display("FAIL level_drop_N2 got %h want 00000010", irq_o); end
      @(posedge clk); #1;
      n_vec++; if (irq_o !== 32'h0) begin n_err++; $display("FAIL level_drop_N3 got %h want 0", irq_o); end
   endtask

   task automatic test_collision();
      logic [31:0] rd;
      logic        rdy;
      @(negedge clk); irq_src[0] = 1'b1;
      @(negedge clk); irq_src[0] = 1'b0;
      repeat (5) @(posedge clk);
      // fresh rise: sync sees it at N+1, PENDING set lands at N+2 with the W1C commit
      @(negedge clk); irq_src[0] = 1'b1;
      @(posedge clk);
      @(negedge clk); irq_src[0] = 1'b0;
      @(posedge clk); #1;
      bus(4'h0, 4'b1111, 32'h0000_0001, rd, rdy);
      bus(4'h0, 4'b0000, 32'h0, rd, rdy);
      n_vec++; if (rd !== 32'h0000_0001) begin n_err++; $display("FAIL collision_pending got %h want 00000001", rd); end
      @(negedge clk); eoi = 32'h0000_0008;
      @(negedge clk); eoi = 32'h0;
      bus(4'h0, 4'b0000, 32'h0, rd, rdy);
      n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL eoi_pending got %h want 0", rd); end
   endtask

   task automatic test_gating_and_abort();
      logic [31:0] rd;
      logic        rdy;
      bus(4'h4, 4'b1111, 32'h0, rd, rdy);
      bus(4'h8, 4'b1111, 32'h0000_0005, rd, rdy);
      @(negedge clk); irq_src[2] = 1'b1;
      @(negedge clk); irq_src[2] = 1'b0;
      repeat (4) @(posedge clk);
      bus(4'hC, 4'b0000, 32'h0, rd, rdy);
      n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL gated_status got %h want 0", rd); end
      bus(4'h0, 4'b0000, 32'h0, rd, rdy);
      n_vec++; if (rd !== 32'h0000_0004) begin n_err++; $display("FAIL gated_pending got %h want 00000004", rd); end
      n_vec++; if (irq_o !== 32'h0) begin n_err++; $display("FAIL gated_irq got %h want 0", irq_o); end
      bus(4'h4, 4'b1111, 32'h0000_0004, rd, rdy);
      n_vec++; if (irq_o !== 32'h0) begin n_err++; $display("FAIL enable_irq_at_ready got %h want 0", irq_o); end
      @(posedge clk); #1;
      n_vec++; if (irq_o !== 32'h0000_0020) begin n_err++; $display("FAIL enable_irq_after got %h want 00000020", irq_o); end
      bus(4'hC, 4'b1111, 32'h0000_00FF, rd, rdy);
      bus(4'hC, 4'b0000, 32'h0, rd, rdy);
      n_vec++; if (rd !== 32'h0000_0004) begin n_err++; $display("FAIL status_ro got %h want 00000004", rd); end
      bus(4'h8, 4'b0000, 32'h0, rd, rdy);
      n_vec++; if (rd !== 32'h0000_0005) begin n_err++; $display("FAIL edge_readback got %h want 00000005", rd); end
      // reset while a read is being returned
      @(negedge clk);
      irq_sel = 1'b1; addr = 4'h0; wstrb = 4'b0000;
      @(posedge clk); #1;
      n_vec++; if (data_o !== 32'h0000_0004) begin n_err++; $display("FAIL abort_pre_data got %h want 00000004", data_o); end
      reset = 1'b1; #1;
      n_vec++; if (irq_ready !== 1'b0) begin n_err++; $display("FAIL abort_ready got %b want 0", irq_ready); end
      n_vec++; if (data_o !== 32'h0) begin n_err++; $display("FAIL abort_data got %h want 0", data_o); end
      n_vec++; if (irq_o !== 32'h0) begin n_err++; $display("FAIL abort_irq got %h want 0", irq_o); end
      // a write presented during reset must not land
      @(negedge clk);
      addr = 4'h4; wstrb = 4'b1111; data_i = 32'h0000_00FF;
      @(posedge clk);
      @(negedge clk);
      irq_sel = 1'b0; wstrb = 4'b0000; data_i = '0; reset = 1'b0;
      for (int r = 0; r < 4; r++) begin
         bus(4'(r * 4), 4'b0000, 32'h0, rd, rdy);
         n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL abort_reg[%0d] got %h want 0", r, rd); end
      end
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      reset = 1'b1; irq_sel = 1'b0; addr = '0; wstrb = '0; data_i = '0;
      irq_src = '0; eoi = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      test_reset();
      test_enable_write();
      test_edge();
      test_level();
      test_collision();
      test_gating_and_abort();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running want finished");
      $fatal(1, "timeout");
   end

endmodule
